// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned display commit.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).

module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      4'hF: seg = 7'h38;
      default: seg = 7'h7F;
    endcase
  end

endmodule

module seg_scan_ctrl #(
  parameter int NDIGITS   = 8,
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [4*NDIGITS-1:0]   wr_data,
  input  logic [NDIGITS-1:0]     digit_en,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   frame_done
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? ((DIV > 2) ? DIV : 2)
                                             : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam int IW = $clog2(NDIGITS);
  localparam int DW = 4 * NDIGITS;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } st_t;

  // With no dead time the controller lives in SCAN permanently
  localparam st_t ST_IDLE = (BLANK_CYC == 0) ? ST_SCAN : ST_BLANK;

  st_t             st_r, st_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]   disp_r;
  logic [DW-1:0]   shadow_r;
  logic            pending_r;
  logic            wrap_s;
  logic [3:0]      nib_s;
  logic [6:0]      dec_s;
  logic            lz_hit_s;
  logic [NDIGITS-1:0] an_s;
  logic [6:0]      seg_s;

  // Slot sequencing: dead time, then DIV cycles of drive, then next digit
  always_comb begin
    st_s   = st_r;
    idx_s  = idx_r;
    cnt_s  = cnt_r;
    wrap_s = 1'b0;
    case (st_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          st_s  = ST_SCAN;
          cnt_s = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_SCAN: begin
        if (cnt_r == DIV_LAST) begin
          st_s  = ST_IDLE;
          cnt_s = {CW{1'b0}};
          if (idx_r == IDX_LAST) begin
            idx_s  = {IW{1'b0}};
            wrap_s = 1'b1;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        st_s  = ST_IDLE;
        cnt_s = {CW{1'b0}};
        idx_s = {IW{1'b0}};
      end
    endcase
  end

  // State, display word and one-deep shadow; commit only at the frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r       <= ST_IDLE;
      idx_r      <= {IW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      disp_r     <= {DW{1'b0}};
      shadow_r   <= {DW{1'b0}};
      pending_r  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st_r       <= st_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      frame_done <= wrap_s;
      if (wrap_s && pending_r) begin
        disp_r    <= shadow_r;
        pending_r <= 1'b0;
      end else if (wr_valid && !pending_r) begin
        shadow_r  <= wr_data;
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign nib_s = disp_r[{idx_r, 2'b00} +: 4];

  hex7seg u_dec (
    .nib (nib_s),
    .seg (dec_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIGITS-1:0] lz_s;
  logic               zero_s;

  // A digit is a leading zero when it and every nibble above it are zero
  always_comb begin
    zero_s = 1'b1;
    lz_s   = {NDIGITS{1'b0}};
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_s  = zero_s & (disp_r[4*i +: 4] == 4'h0);
      lz_s[i] = zero_s & (i != 0);
    end
  end

  assign lz_hit_s = lz_s[idx_r];
`else
  assign lz_hit_s = 1'b0;
`endif

  // Pin drive: disabled digits keep their slot but stay dark
  always_comb begin
    an_s  = {NDIGITS{1'b1}};
    seg_s = 7'h7F;
    if ((st_r == ST_SCAN) && digit_en[idx_r]) begin
      an_s = ~({{(NDIGITS-1){1'b0}}, 1'b1} << idx_r);
      if (lz_hit_s) begin
        seg_s = 7'h7F;
      end else begin
        seg_s = dec_s;
      end
    end else begin
      an_s  = {NDIGITS{1'b1}};
      seg_s = 7'h7F;
    end
  end

  assign an       = an_s;
  assign seg      = seg_s;
  assign wr_ready = ~pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIGITS=4, DIV=4, BLANK_CYC=2).
// Reference model derives everything from the cycle number since reset.

module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIVP  = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = BLK + DIVP;
  localparam int FRAME = N * SLOT;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [15:0]   wr_data;
  logic [3:0]    digit_en;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          frame_done;

  seg_scan_ctrl #(.NDIGITS(N), .DIV(DIVP), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
    int         t;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  logic        m_pend = 1'b0;
  logic        m_rst = 1'b1;
  logic        m_valid = 1'b0;
  logic [15:0] m_data = 16'h0;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    return tbl[n];
  endfunction

  task automatic model_edge();
    int nt;
    if (m_rst) begin
      m_t = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
    end else begin
      nt = m_t + 1;
      if ((nt % FRAME == 0) && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (m_valid && !m_pend) begin
        m_shadow = m_data;
        m_pend   = 1'b1;
      end
      m_t = nt;
    end
  endtask

  function automatic exp_t model_out(input logic r, input logic [3:0] en);
    exp_t e;
    int p, slot, ph;
    logic [15:0] upper;
    e.t = m_t;
    if (r) begin
      e.an = 4'hF; e.seg = 7'h7F; e.fd = 1'b0; e.rdy = 1'b1;
    end else begin
      p    = m_t % FRAME;
      slot = p / SLOT;
      ph   = p % SLOT;
      e.fd  = (m_t > 0) && (p == 0);
      e.rdy = !m_pend;
      if (ph < BLK || !en[slot]) begin
        e.an = 4'hF; e.seg = 7'h7F;
      end else begin
        e.an  = 4'hF & ~(4'(1) << slot);
        e.seg = hexseg(4'((m_disp >> (4 * slot)) & 16'hF));
`ifdef LEADING_ZERO_BLANK_EN
        upper = m_disp >> (4 * slot);
        if (slot != 0 && upper == 16'h0) e.seg = 7'h7F;
`else
        upper = 16'h0;
`endif
      end
    end
    return e;
  endfunction

  // one clock: advance the model, drive this cycle's inputs, queue expectation
  task automatic cyc(input logic r, input logic v, input logic [15:0] d, input logic [3:0] en);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; wr_valid = v; wr_data = d; digit_en = en;
    m_rst = r; m_valid = v; m_data = d;
    expq.push_back(model_out(r, en));
  endtask

  task automatic chk(input string name, input int t, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, got, want);
    end
  endtask

  // monitor: pop one expectation per cycle and compare the presented outputs
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("an",         e.t, int'(an),         int'(e.an));
      chk("seg",        e.t, int'(seg),        int'(e.seg));
      chk("frame_done", e.t, int'(frame_done), int'(e.fd));
      chk("wr_ready",   e.t, int'(wr_ready),   int'(e.rdy));
    end
  end

  initial begin
    logic [3:0] en_r;
    bit         found;
    rst = 1'b1; wr_valid = 1'b0; wr_data = 16'h0; digit_en = 4'hF;
    repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'hF);

    // reset release, word 1234 offered in cycle 3, commit at first boundary
    for (int c = 0; c < 60; c++) cyc(1'b0, c == 3, 16'h1234, 4'hF);

    // one word accepted, a second held on wr_valid while pending
    cyc(1'b0, 1'b1, 16'h9A0F, 4'hF);
    for (int c = 0; c < 40; c++) cyc(1'b0, 1'b1, 16'hBEEF, 4'hF);
    for (int c = 0; c < 30; c++) cyc(1'b0, 1'b0, 16'h0, 4'hF);

    // digit 2 disabled for two frames
    for (int c = 0; c < 2 * FRAME; c++) cyc(1'b0, 1'b0, 16'h0, 4'b1011);

    // reset in the middle of digit 2's drive while a word is pending
    found = 1'b0;
    for (int c = 0; c < 4 * FRAME && !found; c++) begin
      cyc(1'b0, 1'b1, 16'h4321, 4'hF);
      if (m_pend && (m_t % FRAME == 2 * SLOT + BLK)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_setup t=%0d got=0 expected=1", m_t);
    end
    repeat (2) cyc(1'b1, 1'b1, 16'h4321, 4'hF);
    for (int c = 0; c < 30; c++) cyc(1'b0, 1'b0, 16'h0, 4'hF);

    // leading-zero patterns (plain decode in the default build)
    cyc(1'b0, 1'b1, 16'h0050, 4'hF);
    for (int c = 0; c < 2 * FRAME; c++) cyc(1'b0, 1'b0, 16'h0, 4'hF);
    cyc(1'b0, 1'b1, 16'h0000, 4'hF);
    for (int c = 0; c < 2 * FRAME; c++) cyc(1'b0, 1'b0, 16'h0, 4'hF);

    // randomized traffic, enables and occasional resets
    en_r = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if (c % FRAME == 7) en_r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0, 16'($urandom), en_r);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain t=%0d got=%0d expected=0", m_t, expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
